keyboard_scan_controller: RTL and testbench
===========================================

// Module: keyboard_scan_controller
// PURPOSE
// - Sequences the 8x5 key matrix: one-hot column drive, settle wait, one-cycle read strobe, row capture.
// - Debounces all 40 keys and queues press/release events for the emulator front panel through a small FIFO.
// - Sits between the physical matrix pins and the keyboard state register file.
// - Its kbCol/read outputs feed that register file's Cs/En inputs directly.
// PARAMETERS
// COLS            8   matrix columns (kbCol width)
// ROWS            5   matrix rows sampled (kbRow width)
// SETTLE_CYCLES   4   Clk cycles a column is driven before sampling (>=1)
// DEBOUNCE_SCANS  3   consecutive frames a raw value must differ from stable before it flips (>=1)
// FIFO_DEPTH      4   event queue entries (power of two)
// PORTS
// Clk             in   1          system clock; all state updates on posedge
// Rst             in   1          asynchronous, active-high reset
// Enable          in   1          run scanning; sampled at frame start only
// kbRow           in   ROWS       row sense lines, active-high, valid after settle
// kbCol           out  COLS       one-hot column drive; all-zero when idle
// read            out  1          one-cycle sample strobe, coincident with row capture
// keysStable      out  COLS*ROWS  debounced key state; bit c*ROWS+r = column c, row r
// evValid         out  1          event FIFO non-empty
// evReady         in   1          consumer accepts head event when evValid&evReady
// evCode          out  6          keycode c*ROWS+r of head event
// evPressed       out  1          1=press, 0=release
// overflow        out  1          sticky: an event was dropped on full FIFO
// clearOverflow   in   1          clears overflow; loses to a same-cycle set
// BEHAVIOUR
// - Reset: FSM=IDLE, col=0, kbCol=0, read=0, keysStable=0, raw buffer=0, debounce counters=0, FIFO empty, evValid=0, evCode=0, evPressed=0, overflow=0.
// - FSM states and transitions:
//   - IDLE: kbCol=0. If Enable, go to DRIVE with col=0.
//   - DRIVE: kbCol=1<<col. Stay SETTLE_CYCLES cycles, then go to SAMPLE.
//   - SAMPLE: kbCol held, read=1 for exactly one cycle, raw[col*ROWS+:ROWS]<=kbRow.
//     - If col<COLS-1: col++, go to DRIVE.
//     - Else: col=0, k=0, go to COMMIT.
//   - COMMIT: kbCol=0; processes one key k per cycle, k=0..COLS*ROWS-1 in ascending order.
//     - raw[k]==stable[k]: cnt[k]<=0.
//     - Otherwise cnt[k]++. When cnt[k]+1==DEBOUNCE_SCANS: stable[k]<=raw[k], cnt[k]<=0, push {k,raw[k]}.
//     - After the last k: go to DRIVE if Enable, else IDLE.
// - Frame length: COLS*(SETTLE_CYCLES+1)+COLS*ROWS cycles (80 with defaults).
// - Event latency: a held change is reported DEBOUNCE_SCANS frames after first capture.
//   - It is pushed in the COMMIT cycle of its own key index.
// - Glitch rejection: a change lasting fewer than DEBOUNCE_SCANS frames produces no event and resets cnt.
// - Multiple keys flipping in one frame are queued in ascending keycode order, one per cycle.
// - FIFO rules:
//   - Head is visible combinationally on evCode/evPressed.
//   - Pop on evValid&evReady. A pop on empty is ignored.
//   - Push when full with no same-cycle pop: event dropped, stable still flips, overflow<=1.
//   - Push when full with a same-cycle pop: accepted, no overflow.
// - Enable deassert mid-frame: the current frame completes including COMMIT, then IDLE.
//   - The raw buffer is kept; the counters are kept.
// - Rst mid-operation: immediate return to reset state; pending events are discarded.
// - kbCol is never multi-hot. read is never high outside SAMPLE.
// STRUCTURE
// - Shared package dpc_keyboard_pkg:
//   - KB_COLS, KB_ROWS, KB_KEYS.
//   - KEYBOARD_*_KEY keycode constants.
//   - typedef enum kb_scan_state_t {IDLE, DRIVE, SAMPLE, COMMIT}.
//   - typedef struct kb_event_t {code[5:0], pressed}.
// - Sub-module kb_event_fifo: synchronous FIFO of kb_event_t with push/pop/full/empty, DEPTH parameter, async active-high reset.
// - Everything else (FSM, counters, debounce array) lives in this module.
// TESTING
// 1 Reset, Enable=1, kbRow=0: kbCol walks 01,02,..,80.
//   - Each column is held 5 cycles with read on the 5th; kbCol=0 for 40 COMMIT cycles; no events.
// 2 Hold key col2/row3 (kbRow=5'b01000 while kbCol=8'h04) for 3 frames:
//   - keysStable[13]=1 after frame 3 COMMIT; one event code=13 pressed=1.
//   - Release for 3 frames: event code=13 pressed=0.
// 3 Assert col2/row3 for 2 frames only: no event, keysStable[13] stays 0.
//   - A later 3-frame press still needs all 3 frames.
// 4 Press keycodes 39, 0 and 20 together, evReady=0:
//   - FIFO holds 0, 20, 39 in that order; overflow stays 0.
//   - Adding a 5th event with 4 already queued sets overflow=1; clearOverflow drops it.
// 5 Drop Enable during column 3 of a frame:
//   - The frame finishes through COMMIT, then IDLE with kbCol=0 and read=0.
//   - Re-enable: the scan restarts at column 0.
// 6 Pulse Rst during COMMIT with events queued:
//   - All outputs return to reset values immediately; evValid=0.

Source files
------------

// File: rtl/dpc_keyboard_pkg.sv
// Shared types and constants for the keyboard matrix scanner.
// Keycodes are column*KB_ROWS+row.
package dpc_keyboard_pkg;

  localparam int KB_COLS = 8;
  localparam int KB_ROWS = 5;
  localparam int KB_KEYS = KB_COLS * KB_ROWS;

  localparam logic [5:0] KEYBOARD_RUN_KEY   = 6'd0;
  localparam logic [5:0] KEYBOARD_STEP_KEY  = 6'd1;
  localparam logic [5:0] KEYBOARD_RESET_KEY = 6'd13;
  localparam logic [5:0] KEYBOARD_LOAD_KEY  = 6'd20;
  localparam logic [5:0] KEYBOARD_ENTER_KEY = 6'd39;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    SAMPLE,
    COMMIT
  } kb_scan_state_t;

  typedef struct packed {
    logic [5:0] code;
    logic       pressed;
  } kb_event_t;

endpackage

// File: rtl/kb_event_fifo.sv
// Small synchronous event queue; head is visible combinationally.
// A push into a full queue is accepted only alongside a pop.
module kb_event_fifo
  import dpc_keyboard_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      push_i,
  input  kb_event_t data_i,
  input  logic      pop_i,
  output kb_event_t head_o,
  output logic      full_o,
  output logic      empty_o
);

  localparam int AW = $clog2(DEPTH);

  kb_event_t   mem_q [DEPTH];
  logic [AW:0] wr_q;
  logic [AW:0] rd_q;
  logic        do_push;
  logic        do_pop;

  assign empty_o = wr_q == rd_q;
  assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign head_o  = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wr_q[AW-1:0]] <= data_i;
        wr_q                <= wr_q + 1'b1;
      end
      if (do_pop) begin
        rd_q <= rd_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/keyboard_scan_controller.sv
// Scans the key matrix column by column, debounces every key once
// per frame and queues press/release events for the front panel.
module keyboard_scan_controller
  import dpc_keyboard_pkg::*;
#(
  parameter int COLS           = KB_COLS,
  parameter int ROWS           = KB_ROWS,
  parameter int SETTLE_CYCLES  = 4,
  parameter int DEBOUNCE_SCANS = 3,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 Enable,
  input  logic [ROWS-1:0]      kbRow,
  output logic [COLS-1:0]      kbCol,
  output logic                 read,
  output logic [COLS*ROWS-1:0] keysStable,
  output logic                 evValid,
  input  logic                 evReady,
  output logic [5:0]           evCode,
  output logic                 evPressed,
  output logic                 overflow,
  input  logic                 clearOverflow
);

  localparam int KEYS = COLS * ROWS;
  localparam int CLW  = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int SW   = $clog2(SETTLE_CYCLES + 1);
  localparam int CW   = $clog2(DEBOUNCE_SCANS + 1);

  localparam logic [CLW-1:0]  COL_LAST = CLW'(COLS - 1);
  localparam logic [SW-1:0]   SET_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [5:0]      KEY_LAST = 6'(KEYS - 1);
  localparam logic [CW:0]     DB_LIM   = (CW + 1)'(DEBOUNCE_SCANS);
  localparam logic [COLS-1:0] COL0     = {{(COLS - 1){1'b0}}, 1'b1};

  kb_scan_state_t  state_q;
  logic [CLW-1:0]  col_q;
  logic [SW-1:0]   settle_q;
  logic [5:0]      k_q;
  logic [COLS-1:0] kbCol_q;
  logic            read_q;
  logic [KEYS-1:0] raw_q;
  logic [KEYS-1:0] stable_q;
  logic [CW-1:0]   cnt_q [KEYS];
  logic            overflow_q;

  logic            same_d;
  logic            flip_d;
  logic [CW:0]     cnt_inc_d;
  kb_event_t       push_ev_d;
  kb_event_t       head_ev;
  logic            pop_d;
  logic            full_d;
  logic            empty_d;
  logic            ovf_set_d;

  // Debounce decision for the key currently visited by COMMIT.
  always_comb begin
    same_d    = raw_q[k_q] == stable_q[k_q];
    cnt_inc_d = {1'b0, cnt_q[k_q]} + 1'b1;
    flip_d    = (state_q == COMMIT) && !same_d &&
                (cnt_inc_d == DB_LIM);
    push_ev_d = '{code: k_q, pressed: raw_q[k_q]};
  end

  assign pop_d     = evValid && evReady;
  assign ovf_set_d = flip_d && full_d && !pop_d;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q    <= IDLE;
      col_q      <= '0;
      settle_q   <= '0;
      k_q        <= '0;
      kbCol_q    <= '0;
      read_q     <= 1'b0;
      raw_q      <= '0;
      stable_q   <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < KEYS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      read_q <= 1'b0;
      if (ovf_set_d) begin
        overflow_q <= 1'b1;
      end else if (clearOverflow) begin
        overflow_q <= 1'b0;
      end
      unique case (state_q)
        IDLE: begin
          if (Enable) begin
            state_q  <= DRIVE;
            col_q    <= '0;
            settle_q <= '0;
            kbCol_q  <= COL0;
          end
        end
        DRIVE: begin
          if (settle_q == SET_LAST) begin
            state_q <= SAMPLE;
            read_q  <= 1'b1;
          end else begin
            settle_q <= settle_q + 1'b1;
          end
        end
        SAMPLE: begin
          raw_q[col_q*ROWS +: ROWS] <= kbRow;
          settle_q                  <= '0;
          if (col_q == COL_LAST) begin
            state_q <= COMMIT;
            col_q   <= '0;
            k_q     <= '0;
            kbCol_q <= '0;
          end else begin
            state_q <= DRIVE;
            col_q   <= col_q + 1'b1;
            kbCol_q <= kbCol_q << 1;
          end
        end
        COMMIT: begin
          if (same_d) begin
            cnt_q[k_q] <= '0;
          end else if (flip_d) begin
            stable_q[k_q] <= raw_q[k_q];
            cnt_q[k_q]    <= '0;
          end else begin
            cnt_q[k_q] <= cnt_inc_d[CW-1:0];
          end
          if (k_q == KEY_LAST) begin
            k_q <= '0;
            if (Enable) begin
              state_q <= DRIVE;
              kbCol_q <= COL0;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  kb_event_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (Clk),
    .rst_i   (Rst),
    .push_i  (flip_d),
    .data_i  (push_ev_d),
    .pop_i   (pop_d),
    .head_o  (head_ev),
    .full_o  (full_d),
    .empty_o (empty_d)
  );

  assign kbCol      = kbCol_q;
  assign read       = read_q;
  assign keysStable = stable_q;
  assign evValid    = !empty_d;
  assign evCode     = head_ev.code;
  assign evPressed  = head_ev.pressed;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_keyboard_scan_controller.sv
// Bench for keyboard_scan_controller: a key-matrix model drives kbRow,
// a frame-level debounce model predicts keys and events.
module tb_keyboard_scan_controller;

  logic        Clk;
  logic        Rst;
  logic        Enable;
  logic [4:0]  kbRow;
  logic [7:0]  kbCol;
  logic        read;
  logic [39:0] keysStable;
  logic        evValid;
  logic        evReady;
  logic [5:0]  evCode;
  logic        evPressed;
  logic        overflow;
  logic        clearOverflow;

  logic [39:0] matrix;

  keyboard_scan_controller dut (
    .Clk           (Clk),
    .Rst           (Rst),
    .Enable        (Enable),
    .kbRow         (kbRow),
    .kbCol         (kbCol),
    .read          (read),
    .keysStable    (keysStable),
    .evValid       (evValid),
    .evReady       (evReady),
    .evCode        (evCode),
    .evPressed     (evPressed),
    .overflow      (overflow),
    .clearOverflow (clearOverflow)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Physical matrix: a driven column exposes its pressed rows.
  always_comb begin
    kbRow = '0;
    for (int c = 0; c < 8; c++) begin
      if (kbCol[c]) kbRow = kbRow | matrix[c*5 +: 5];
    end
  end

  typedef struct {
    int code;
    bit pressed;
  } mev_t;

  typedef struct {
    logic [39:0] keys;
    int          frames;
    logic [39:0] stable;
    bit          has_ev;
    int          code;
    bit          pressed;
  } vec_t;

  int      n_tests;
  int      n_fail;
  bit [39:0] m_stable;
  int      m_cnt [40];
  mev_t    m_q [$];
  bit      m_ovf;
  int      popped [$];
  vec_t    vecs [7];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  function automatic void model_reset;
    m_stable = '0;
    for (int k = 0; k < 40; k++) m_cnt[k] = 0;
    m_q.delete();
    m_ovf = 1'b0;
  endfunction

  // One frame's debounce outcome, keys in ascending order, no pops
  // possible while keys are being committed.
  function automatic void model_commit(input logic [39:0] sampled);
    mev_t e;
    for (int k = 0; k < 40; k++) begin
      if (sampled[k] == m_stable[k]) begin
        m_cnt[k] = 0;
      end else begin
        m_cnt[k] = m_cnt[k] + 1;
        if (m_cnt[k] >= 3) begin
          m_stable[k] = sampled[k];
          m_cnt[k]    = 0;
          e.code      = k;
          e.pressed   = sampled[k];
          if (m_q.size() < 4) m_q.push_back(e);
          else m_ovf = 1'b1;
        end
      end
    end
  endfunction

  // Runs one 80-cycle frame starting at its first DRIVE cycle.
  task automatic frame(input bit drain, input bit clr, input bit drop);
    int bad;
    int first_bad;
    logic [7:0] exp_col;
    logic exp_rd;
    bad = 0;
    first_bad = -1;
    for (int i = 0; i < 80; i++) begin
      exp_col = (i < 40) ? 8'(1 << (i / 5)) : 8'h00;
      exp_rd  = (i < 40) && (i % 5 == 4);
      if (kbCol !== exp_col || read !== exp_rd) begin
        bad++;
        if (first_bad < 0) first_bad = i;
      end
      evReady = 1'b0;
      if (drain && i < 40) begin
        if (m_q.size() > 0) begin
          chk("ev_valid", evValid, 1);
          chk("ev_code", evCode, m_q[0].code);
          chk("ev_pressed", evPressed, m_q[0].pressed);
          popped.push_back(int'(evCode));
          void'(m_q.pop_front());
          evReady = 1'b1;
        end else begin
          evReady = 1'($urandom_range(0, 1));
        end
      end
      clearOverflow = clr && (i == 1);
      if (clr && i == 1) m_ovf = 1'b0;
      if (drop && i == 17) Enable = 1'b0;
      tick();
    end
    evReady = 1'b0;
    clearOverflow = 1'b0;
    model_commit(matrix);
    if (bad != 0) $display("FAIL scan: %0d bad cycles, first at %0d, required 0",
                           bad, first_bad);
    n_tests++;
    if (bad != 0) n_fail++;
    chk("stable", keysStable, m_stable);
    chk("overflow", overflow, m_ovf);
    chk("ev_pending", evValid, m_q.size() != 0);
    if (m_q.size() != 0) chk("ev_head", evCode, m_q[0].code);
  endtask

  localparam logic [39:0] K13 = 40'h1 << 13;

  initial begin
    n_tests = 0;
    n_fail = 0;
    matrix = '0;
    Rst = 1'b1;
    Enable = 1'b0;
    evReady = 1'b0;
    clearOverflow = 1'b0;
    model_reset();

    vecs[0] = '{K13,   3, K13,   1, 13, 1};
    vecs[1] = '{40'h0, 3, 40'h0, 1, 13, 0};
    vecs[2] = '{K13,   2, 40'h0, 0, 0,  0};
    vecs[3] = '{40'h0, 1, 40'h0, 0, 0,  0};
    vecs[4] = '{K13,   2, 40'h0, 0, 0,  0};
    vecs[5] = '{K13,   1, K13,   1, 13, 1};
    vecs[6] = '{40'h0, 3, 40'h0, 1, 13, 0};

    repeat (2) tick();
    chk("rst_kbCol", kbCol, 0);
    chk("rst_read", read, 0);
    chk("rst_stable", keysStable, 0);
    chk("rst_evValid", evValid, 0);
    chk("rst_evCode", evCode, 0);
    chk("rst_evPressed", evPressed, 0);
    chk("rst_overflow", overflow, 0);
    Rst = 1'b0;
    tick();
    chk("idle_kbCol", kbCol, 0);
    Enable = 1'b1;
    tick();

    // Idle matrix: plain column walk, no events.
    frame(1, 0, 0);

    // Directed press / release / glitch rows.
    for (int v = 0; v < 7; v++) begin
      matrix = vecs[v].keys;
      for (int f = 0; f < vecs[v].frames; f++) frame(1, 0, 0);
      chk("vec_stable", keysStable, vecs[v].stable);
      chk("vec_evValid", evValid, vecs[v].has_ev);
      if (vecs[v].has_ev) begin
        chk("vec_evCode", evCode, vecs[v].code);
        chk("vec_evPressed", evPressed, vecs[v].pressed);
      end
    end
    frame(1, 0, 0);

    // Simultaneous presses queue in keycode order; a fifth overflows.
    matrix = (40'h1 << 39) | 40'h1 | (40'h1 << 20);
    repeat (3) frame(0, 0, 0);
    chk("q_head0", evCode, 0);
    chk("q_ovf0", overflow, 0);
    matrix = matrix | (40'h1 << 7) | (40'h1 << 8);
    repeat (3) frame(0, 0, 0);
    chk("q_ovf1", overflow, 1);
    chk("q_key8", keysStable[8], 1);
    popped.delete();
    frame(1, 1, 0);
    chk("q_popcount", popped.size(), 4);
    if (popped.size() == 4) begin
      chk("q_order0", popped[0], 0);
      chk("q_order1", popped[1], 20);
      chk("q_order2", popped[2], 39);
      chk("q_order3", popped[3], 7);
    end
    chk("q_ovf_clr", overflow, 0);
    matrix = '0;
    repeat (3) frame(1, 0, 0);

    // Random toggling of a few keys, random draining.
    for (int f = 0; f < 30; f++) begin
      int rk [6];
      rk = '{1, 13, 22, 30, 38, 39};
      for (int j = 0; j < 6; j++) begin
        if ($urandom_range(0, 3) == 0) matrix[rk[j]] = ~matrix[rk[j]];
      end
      frame($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, 0);
    end
    matrix = '0;
    frame(1, 1, 0);
    repeat (3) frame(1, 0, 0);

    // Enable dropped mid-frame: frame completes, then idle.
    frame(1, 0, 1);
    for (int i = 0; i < 5; i++) begin
      chk("idle_outs", {kbCol, read}, 9'h0);
      tick();
    end
    Enable = 1'b1;
    tick();
    chk("restart_col0", kbCol, 8'h01);
    frame(1, 0, 0);

    // Reset during COMMIT with an event queued.
    matrix = 40'h1 << 5;
    repeat (3) frame(0, 0, 0);
    repeat (50) tick();
    chk("pre_rst_valid", evValid, 1);
    Rst = 1'b1;
    #1;
    chk("mid_rst_kbCol", kbCol, 0);
    chk("mid_rst_read", read, 0);
    chk("mid_rst_stable", keysStable, 0);
    chk("mid_rst_evValid", evValid, 0);
    chk("mid_rst_evCode", evCode, 0);
    chk("mid_rst_evPressed", evPressed, 0);
    chk("mid_rst_overflow", overflow, 0);
    Rst = 1'b0;
    model_reset();
    matrix = '0;
    tick();
    chk("post_rst_col0", kbCol, 8'h01);
    frame(1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
